// File: rtl/spimem_pkg.sv
// spimem_pkg: shared FSM state/led codes and bit-counter width helper for spi_burst_memory
package spimem_pkg;
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CMD      = 4'd1,
    RD_LOAD  = 4'd2,
    RD_SHIFT = 4'd3,
    WR_SHIFT = 4'd4,
    WR_STORE = 4'd5,
    HOLD     = 4'd6
  } state_t;
  function automatic int cnt_w(input int addr_w, input int data_w);
    return $clog2((addr_w + 1 > data_w) ? addr_w + 1 : data_w) + 1;
  endfunction
endpackage

// File: rtl/spimem_sync_edge.sv
// spimem_sync_edge: STAGES-flop synchroniser with one-clk rise/fall pulses
//   ports: clk, rst_n (async, active low), i_pin (async input),
//          o_level (synchronised level), o_rise/o_fall (one-clk edge pulses)
module spimem_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= (r_sync << 1) | STAGES'(i_pin);
      r_prev <= r_sync[STAGES-1];
    end
  assign o_level = r_sync[STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;
endmodule

// File: rtl/spi_burst_memory.sv
// spi_burst_memory: SPI mode-0 slave giving read/write access to a 2**ADDR_W x DATA_W memory
//   ports: clk, rst_n (async, active low), sclk_pin/cs_pin/mosi_pin (SPI inputs),
//          miso_pin/miso_oe (SPI output + tristate enable), leds (current FSM state code)
//   frame: CS low, ADDR_W address bits + R/W bit (1 = read), then DATA_W-bit data words, MSB first
//   SPIMEM_BURST_EN: defined -> address auto-increments across words until CS rises;
//                    undefined -> one data word, then HOLD until CS rises
module spi_burst_memory
  import spimem_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic       miso_oe,
  output logic [3:0] leds
);
  localparam int CNT_W = cnt_w(ADDR_W, DATA_W);
  localparam int RX_W  = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
`ifdef SPIMEM_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif
  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [RX_W-1:0]   r_rx;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_tx;
  logic              r_miso;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic w_cs_hi, w_cs_rise, w_cs_fall;
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_rise, w_fall, w_cmd_last, w_data_last, w_shift_in, w_count, w_tx_fall;
  logic w_cmd_done, w_inc, w_unused;
  spimem_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .i_pin(cs_pin),
    .o_level(w_cs_hi), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  spimem_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .i_pin(sclk_pin),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  spimem_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .i_pin(mosi_pin),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));
  assign w_unused = &{w_cs_rise, w_cs_fall, w_sclk_lvl, w_mosi_rise, w_mosi_fall};
  // CS deassertion masks any SCLK edge landing on the same clk
  assign w_rise      = w_sclk_rise & ~w_cs_hi;
  assign w_fall      = w_sclk_fall & ~w_cs_hi;
  assign w_cmd_last  = r_cnt == CNT_W'(ADDR_W);
  assign w_data_last = r_cnt == CNT_W'(DATA_W - 1);
  assign w_shift_in  = w_rise & ((r_state == CMD) | (r_state == WR_SHIFT));
  assign w_count     = w_shift_in | (w_rise & (r_state == RD_SHIFT));
  assign w_tx_fall   = w_fall & (r_state == RD_SHIFT);
  assign w_cmd_done  = (r_state == CMD) & ((w_next == RD_LOAD) | (w_next == WR_SHIFT));
  assign w_inc       = ((r_state == RD_SHIFT) & (w_next == RD_LOAD)) |
                       ((r_state == WR_STORE) & (w_next == WR_SHIFT));
  always_comb begin
    w_next = r_state;
    if (w_cs_hi) w_next = IDLE;
    else
      case (r_state)
        IDLE:     w_next = CMD;
        CMD:      w_next = (w_rise && w_cmd_last) ? (w_mosi ? RD_LOAD : WR_SHIFT) : CMD;
        RD_LOAD:  w_next = RD_SHIFT;
        RD_SHIFT: w_next = (w_rise && w_data_last) ? (BURST ? RD_LOAD : HOLD) : RD_SHIFT;
        WR_SHIFT: w_next = (w_rise && w_data_last) ? WR_STORE : WR_SHIFT;
        WR_STORE: w_next = BURST ? WR_SHIFT : HOLD;
        HOLD:     w_next = HOLD;
        default:  w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rx    <= '0;
      r_addr  <= '0;
      r_tx    <= '0;
      r_miso  <= 1'b0;
    end else begin
      r_state <= w_next;
      // every state change is a word boundary (or frame end), so the counter restarts
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(w_count);
      r_rx    <= w_shift_in ? {r_rx[RX_W-2:0], w_mosi} : r_rx;
      // the R/W bit is being sampled now, so the address is the bits already shifted in
      r_addr  <= w_cmd_done ? r_rx[ADDR_W-1:0] : w_inc ? r_addr + 1'b1 : r_addr;
      r_tx    <= (r_state == RD_LOAD) ? r_mem[r_addr] : w_tx_fall ? r_tx << 1 : r_tx;
      r_miso  <= miso_oe ? (w_tx_fall ? r_tx[DATA_W-1] : r_miso) : 1'b0;
    end
  always_ff @(posedge clk)
    if (r_state == WR_STORE) r_mem[r_addr] <= r_rx[DATA_W-1:0];
  assign miso_oe  = (r_state == RD_LOAD) | (r_state == RD_SHIFT);
  assign miso_pin = miso_oe & r_miso;
  assign leds     = r_state;
endmodule

// File: tb/tb_spi_burst_memory.sv
// tb_spi_burst_memory: directed SPI frames against spi_burst_memory with a read-data scoreboard
module tb_spi_burst_memory;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk_pin = 1'b0;
  logic       cs_pin = 1'b1;
  logic       mosi_pin = 1'b0;
  logic       miso_pin, miso_oe;
  logic [3:0] leds;
`ifdef SPIMEM_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb[$];
  spi_burst_memory dut (
    .clk(clk), .rst_n(rst_n), .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin),
    .miso_pin(miso_pin), .miso_oe(miso_oe), .leds(leds));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  // SCLK period 20 clk; MISO sampled just before each rise, as a mode-0 master does
  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] rx,
                      output logic oe_any, output logic oe_all);
    rx = '0;
    oe_any = 1'b0;
    oe_all = 1'b1;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi_pin = b[i];
      wait_clk(10);
      rx[i] = miso_pin;
      oe_any |= miso_oe;
      oe_all &= miso_oe;
      sclk_pin = 1'b1;
      wait_clk(10);
      sclk_pin = 1'b0;
    end
  endtask
  task automatic cs_fall();
    cs_pin = 1'b0;
    wait_clk(5);
  endtask
  task automatic cs_rise(input string tag);
    cs_pin = 1'b1;
    wait_clk(3);
    chk(tag, leds, 4'd0);
    wait_clk(10);
  endtask
  task automatic wr_frame(input logic [7:0] cmd, input logic [7:0] d0, input logic [7:0] d1,
                          input int n, input logic [3:0] end_leds);
    logic [7:0] rx;
    logic a, b;
    cs_fall();
    xfer(cmd, 8, rx, a, b);
    chk("wr_cmd_oe", a, 1'b0);
    xfer(d0, 8, rx, a, b);
    chk("wr_data_oe", a, 1'b0);
    if (n > 1) xfer(d1, 8, rx, a, b);
    wait_clk(10);
    chk("wr_end_state", leds, end_leds);
    cs_rise("wr_idle");
  endtask
  task automatic rd_frame(input logic [7:0] cmd, input logic [7:0] e0, input logic [7:0] e1,
                          input int n);
    logic [7:0] rx;
    logic a, b;
    sb.push_back(e0);
    if (n > 1) sb.push_back(e1);
    cs_fall();
    xfer(cmd, 8, rx, a, b);
    chk("rd_cmd_oe", a, 1'b0);
    for (int k = 0; k < n; k++) begin
      xfer(8'h00, 8, rx, a, b);
      chk("rd_data", rx, sb.pop_front());
      chk("rd_data_oe", b, 1'b1);
    end
    wait_clk(10);
    chk("rd_end_state", leds, BURST ? 4'd3 : 4'd6);
    chk("rd_end_oe", miso_oe, BURST);
    chk("rd_miso_gated", miso_pin & ~miso_oe, 1'b0);
    cs_rise("rd_idle");
  endtask
  initial begin
    logic [7:0] rx;
    logic a, b;
    wait_clk(3);
    chk("rst_leds", leds, 4'd0);
    chk("rst_oe", miso_oe, 1'b0);
    chk("rst_miso", miso_pin, 1'b0);
    rst_n = 1'b1;
    wait_clk(5);
    chk("idle_after_rst", leds, 4'd0);
    wr_frame(8'h26, 8'h5A, 8'h00, 1, BURST ? 4'd4 : 4'd6);
    wr_frame(8'h10, 8'h3C, 8'h00, 1, BURST ? 4'd4 : 4'd6);
    wr_frame(8'h40, 8'hF0, 8'h00, 1, BURST ? 4'd4 : 4'd6);
    wr_frame(8'h24, 8'hA5, 8'h00, 1, BURST ? 4'd4 : 4'd6);
    rd_frame(8'h25, 8'hA5, 8'h00, 1);
`ifdef SPIMEM_BURST_EN
    wr_frame(8'hFE, 8'h11, 8'h22, 2, 4'd4);
    rd_frame(8'hFF, 8'h11, 8'h22, 2);
`else
    wr_frame(8'h24, 8'h01, 8'h02, 2, 4'd6);
    rd_frame(8'h25, 8'h01, 8'h00, 1);
`endif
    rd_frame(8'h27, 8'h5A, 8'h00, 1);
    cs_fall();
    xfer(8'h10, 8, rx, a, b);
    xfer(8'hFF, 5, rx, a, b);
    chk("partial_state", leds, 4'd4);
    cs_rise("partial_idle");
    rd_frame(8'h11, 8'h3C, 8'h00, 1);
    cs_fall();
    xfer(8'h41, 8, rx, a, b);
    xfer(8'h00, 3, rx, a, b);
    chk("mid_rx", rx, 8'hE0);
    wait_clk(4);
    chk("mid_oe", miso_oe, 1'b1);
    chk("mid_miso", miso_pin, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_oe", miso_oe, 1'b0);
    chk("abort_miso", miso_pin, 1'b0);
    chk("abort_leds", leds, 4'd0);
    cs_pin = 1'b1;
    sclk_pin = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(10);
    chk("post_rst_idle", leds, 4'd0);
    rd_frame(8'h41, 8'hF0, 8'h00, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
